reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-003 SHALL have port REQ_A  input  1  write request, requester A (ALU writeback).
REQ-004 SHALL have port ADDR_A  input  3  destination register, requester A.
REQ-005 SHALL have port DATA_A  input  8  write data, requester A.
REQ-006 SHALL have port ACK_A  output  1  one-cycle grant acknowledge to A.
REQ-007 SHALL have ports REQ_B/ADDR_B/DATA_B/ACK_B, same widths and meanings, requester B (load unit).
REQ-008 SHALL have port REGF_WRITE  output  1  write enable to register file.
REQ-009 SHALL have port REGF_INADDR  output  3  write address to register file.
REQ-010 SHALL have port REGF_IN  output  8  write data to register file.
REQ-011 SHALL have ports RD_ADDR1, RD_ADDR2  input  3  register file read addresses (hazard check).
REQ-012 SHALL have port STALL  output  1  read hazard against in-flight write.

Function
REQ-013 SHALL implement FSM states IDLE, WR_A, WR_B; REGF_WRITE=1 exactly in WR_A/WR_B.
REQ-014 SHALL treat requester X as eligible at a rising edge iff REQ_X=1 and ACK_X=0 at that edge.
REQ-015 SHALL, at each rising edge, go to WR_A/WR_B if a requester is eligible, else IDLE.
REQ-016 SHALL, when only one requester is eligible, grant it.
REQ-017 SHALL, when both are eligible, grant the one not granted last (round-robin via 1-bit LAST register, updated on every grant).
REQ-018 SHALL register REGF_INADDR/REGF_IN from the granted requester's ADDR/DATA at the grant edge; held stable throughout the WR state.
REQ-019 SHALL assert ACK_X for exactly the cycle spent in WR_X; latency REQ sampled to REGF_WRITE = 1 cycle.
REQ-020 SHALL permit back-to-back writes only alternating A/B (same requester minimum 2 cycles apart, per REQ-014).
REQ-021 SHALL require requesters to hold REQ/ADDR/DATA stable until the edge where ACK is seen high; REQ may be reasserted one cycle later.
REQ-022 SHALL hold REGF_INADDR/REGF_IN at last values in IDLE (REGF_WRITE=0 masks them).
REQ-023 SHALL ignore ADDR/DATA of non-granted requester; no data from both requesters merged.

Reset
REQ-024 SHALL, on RESET=1 at rising edge: state=IDLE, REGF_WRITE=0, ACK_A=0, ACK_B=0, REGF_INADDR=0, REGF_IN=0, LAST=B (A wins first tie), STALL=0.
REQ-025 SHALL give RESET priority over any request; a write in progress is dropped without ACK repetition, and no grant occurs on the reset edge.
REQ-026 SHALL resume arbitration on the first rising edge with RESET=0.

Configuration
REQ-027 SHALL compile hazard detection only when macro REGARB_STALL_EN is defined.
REQ-028 SHALL, with REGARB_STALL_EN, drive STALL=1 combinationally when REGF_WRITE=1 and (RD_ADDR1==REGF_INADDR or RD_ADDR2==REGF_INADDR), else 0.
REQ-029 SHALL, without REGARB_STALL_EN, tie STALL to 0; RD_ADDR1/RD_ADDR2 unused.

Verification
REQ-030 SHALL cover single request: REQ_A=1,ADDR_A=3,DATA_A=8'h5A at edge 0 -> cycle 1: REGF_WRITE=1, INADDR=3, IN=5A, ACK_A=1; cycle 2 IDLE.
REQ-031 SHALL cover contention after reset: REQ_A,REQ_B held high -> grants A,B,A,B on consecutive cycles, each ACK one cycle.
REQ-032 SHALL cover single persistent requester: REQ_B held high, no ACK response -> WR_B every other cycle.
REQ-033 SHALL cover reset mid-write: RESET=1 during WR_A -> next cycle REGF_WRITE=0, ACK_A=0, outputs zeroed, then A granted first on tie.
REQ-034 SHALL cover hazard (REGARB_STALL_EN defined): WR_A to reg 5, RD_ADDR2=5 -> STALL=1 that cycle; RD_ADDR1/2=4 -> STALL=0; macro undefined -> STALL=0 always.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Requester/register-file bundle for reg_write_arbiter.
// The master modport is the requester/regfile side; the slave modport is the arbiter.
interface reg_write_arbiter_if;
    logic       REQ_A;
    logic [2:0] ADDR_A;
    logic [7:0] DATA_A;
    logic       ACK_A;
    logic       REQ_B;
    logic [2:0] ADDR_B;
    logic [7:0] DATA_B;
    logic       ACK_B;
    logic       REGF_WRITE;
    logic [2:0] REGF_INADDR;
    logic [7:0] REGF_IN;
    logic [2:0] RD_ADDR1;
    logic [2:0] RD_ADDR2;
    logic       STALL;

    modport master (
        output REQ_A, ADDR_A, DATA_A, REQ_B, ADDR_B, DATA_B, RD_ADDR1, RD_ADDR2,
        input  ACK_A, ACK_B, REGF_WRITE, REGF_INADDR, REGF_IN, STALL
    );
    modport slave (
        input  REQ_A, ADDR_A, DATA_A, REQ_B, ADDR_B, DATA_B, RD_ADDR1, RD_ADDR2,
        output ACK_A, ACK_B, REGF_WRITE, REGF_INADDR, REGF_IN, STALL
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin register-file write arbiter (ALU A, load unit B).
// Optional read-hazard STALL output is built only when REGARB_STALL_EN is defined.
module reg_write_arbiter (
    input  logic                CLK,
    input  logic                RESET,
    reg_write_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WR_A = 2'd1, WR_B = 2'd2} state_t;

    state_t     state, state_nx;
    logic       last, last_nx;      // 0 = A granted last, 1 = B granted last
    logic [2:0] addr_q, addr_nx;
    logic [7:0] data_q, data_nx;
    logic       elig_a, elig_b;

    // A requester whose ACK is high this cycle is being served and cannot re-win.
    assign elig_a = bus.REQ_A & (state != WR_A);
    assign elig_b = bus.REQ_B & (state != WR_B);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            last   <= 1'b1;
            addr_q <= 3'd0;
            data_q <= 8'd0;
        end else begin
            state  <= state_nx;
            last   <= last_nx;
            addr_q <= addr_nx;
            data_q <= data_nx;
        end
    end

    always_comb begin
        state_nx = IDLE;
        last_nx  = last;
        addr_nx  = addr_q;
        data_nx  = data_q;
        if (elig_a && (!elig_b || last)) begin
            state_nx = WR_A;
            last_nx  = 1'b0;
            addr_nx  = bus.ADDR_A;
            data_nx  = bus.DATA_A;
        end else if (elig_b) begin
            state_nx = WR_B;
            last_nx  = 1'b1;
            addr_nx  = bus.ADDR_B;
            data_nx  = bus.DATA_B;
        end
    end

    assign bus.ACK_A       = (state == WR_A);
    assign bus.ACK_B       = (state == WR_B);
    assign bus.REGF_WRITE  = (state == WR_A) || (state == WR_B);
    assign bus.REGF_INADDR = addr_q;
    assign bus.REGF_IN     = data_q;

`ifdef REGARB_STALL_EN
    assign bus.STALL = bus.REGF_WRITE &&
                       ((bus.RD_ADDR1 == addr_q) || (bus.RD_ADDR2 == addr_q));
`else
    logic unused_rd;
    assign unused_rd = ^{bus.RD_ADDR1, bus.RD_ADDR2};
    assign bus.STALL = 1'b0;
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: expected outputs are queued as each
// cycle's stimulus is driven and popped/compared after the following edge.
module tb_reg_write_arbiter;
    logic CLK = 1'b0;
    logic RESET;

    reg_write_arbiter_if bus ();

    reg_write_arbiter dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic       wr;
        logic       ack_a;
        logic       ack_b;
        logic [2:0] addr;
        logic [7:0] data;
        logic       stall;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

`ifdef REGARB_STALL_EN
    localparam logic STALL_ON = 1'b1;
`else
    localparam logic STALL_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Queue the expectation for this cycle's stimulus, clock once, then compare.
    task automatic cyc(input string tag, input logic wr, input logic aa, input logic ab,
                       input logic [2:0] ad, input logic [7:0] dt, input logic st);
        exp_t e;
        e.wr = wr; e.ack_a = aa; e.ack_b = ab; e.addr = ad; e.data = dt; e.stall = st;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk({tag, ".wr"},    32'(bus.REGF_WRITE),  32'(e.wr));
        chk({tag, ".ack_a"}, 32'(bus.ACK_A),       32'(e.ack_a));
        chk({tag, ".ack_b"}, 32'(bus.ACK_B),       32'(e.ack_b));
        chk({tag, ".addr"},  32'(bus.REGF_INADDR), 32'(e.addr));
        chk({tag, ".data"},  32'(bus.REGF_IN),     32'(e.data));
        chk({tag, ".stall"}, 32'(bus.STALL),       32'(e.stall));
    endtask

    task automatic drv(input logic ra, input logic [2:0] aa, input logic [7:0] da,
                       input logic rb, input logic [2:0] ab, input logic [7:0] db);
        bus.REQ_A = ra; bus.ADDR_A = aa; bus.DATA_A = da;
        bus.REQ_B = rb; bus.ADDR_B = ab; bus.DATA_B = db;
    endtask

    initial begin
        RESET = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        bus.RD_ADDR1 = 3'd0;
        bus.RD_ADDR2 = 3'd0;
        cyc("rst", 0, 0, 0, 3'd0, 8'h00, 0);

        // single request; read ports point elsewhere
        RESET = 1'b0;
        bus.RD_ADDR1 = 3'd4; bus.RD_ADDR2 = 3'd4;
        drv(1, 3'd3, 8'h5A, 0, 0, 0);
        cyc("single.wr", 1, 1, 0, 3'd3, 8'h5A, 0);
        cyc("single.held", 0, 0, 0, 3'd3, 8'h5A, 0);
        drv(0, 0, 0, 0, 0, 0);
        cyc("single.idle", 0, 0, 0, 3'd3, 8'h5A, 0);

        // hazard: write reg 5 while RD_ADDR2 reads it, then miss with 4
        bus.RD_ADDR2 = 3'd5;
        drv(1, 3'd5, 8'hC3, 0, 0, 0);
        cyc("haz.hit", 1, 1, 0, 3'd5, 8'hC3, STALL_ON);
        drv(0, 0, 0, 0, 0, 0);
        bus.RD_ADDR2 = 3'd4;
        drv(1, 3'd5, 8'hC4, 0, 0, 0);
        cyc("haz.idle", 0, 0, 0, 3'd5, 8'hC3, 0);
        cyc("haz.miss", 1, 1, 0, 3'd5, 8'hC4, 0);
        drv(0, 0, 0, 0, 0, 0);
        cyc("haz.end", 0, 0, 0, 3'd5, 8'hC4, 0);

        // contention right after reset: A wins first tie, then alternate
        RESET = 1'b1;
        cyc("rst2", 0, 0, 0, 3'd0, 8'h00, 0);
        RESET = 1'b0;
        drv(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
        cyc("rr.a0", 1, 1, 0, 3'd1, 8'h11, 0);
        cyc("rr.b0", 1, 0, 1, 3'd2, 8'h22, 0);
        cyc("rr.a1", 1, 1, 0, 3'd1, 8'h11, 0);
        cyc("rr.b1", 1, 0, 1, 3'd2, 8'h22, 0);
        drv(0, 0, 0, 0, 0, 0);
        cyc("rr.idle", 0, 0, 0, 3'd2, 8'h22, 0);

        // persistent B with no response to ACK: every other cycle
        drv(0, 0, 0, 1, 3'd6, 8'h66);
        cyc("pb.w0", 1, 0, 1, 3'd6, 8'h66, 0);
        cyc("pb.i0", 0, 0, 0, 3'd6, 8'h66, 0);
        cyc("pb.w1", 1, 0, 1, 3'd6, 8'h66, 0);
        cyc("pb.i1", 0, 0, 0, 3'd6, 8'h66, 0);
        drv(0, 0, 0, 0, 0, 0);
        cyc("pb.end", 0, 0, 0, 3'd6, 8'h66, 0);

        // reset in the middle of WR_A, both requesting: reset wins, then A first
        drv(1, 3'd7, 8'h77, 0, 0, 0);
        cyc("rm.wr", 1, 1, 0, 3'd7, 8'h77, 0);
        RESET = 1'b1;
        drv(1, 3'd7, 8'h77, 1, 3'd2, 8'h33);
        cyc("rm.rst", 0, 0, 0, 3'd0, 8'h00, 0);
        RESET = 1'b0;
        cyc("rm.a", 1, 1, 0, 3'd7, 8'h77, 0);
        cyc("rm.b", 1, 0, 1, 3'd2, 8'h33, 0);
        drv(0, 0, 0, 0, 0, 0);
        cyc("rm.idle", 0, 0, 0, 3'd2, 8'h33, 0);

        // random single-shot writes alternating A/B with idle gaps
        for (int i = 0; i < 6; i++) begin
            logic [2:0] ra;
            logic [7:0] rd;
            ra = 3'($urandom_range(0, 7));
            rd = 8'($urandom_range(0, 255));
            if (i % 2 == 0) begin
                drv(1, ra, rd, 0, 0, 0);
                cyc("rnd.a", 1, 1, 0, ra, rd, 0);
            end else begin
                drv(0, 0, 0, 1, ra, rd);
                cyc("rnd.b", 1, 0, 1, ra, rd, 0);
            end
            drv(0, 0, 0, 0, 0, 0);
            cyc("rnd.idle", 0, 0, 0, ra, rd, 0);
        end

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
